updn_cntr_prog: RTL

Parametrised, programmable-limit up/down counter. It is the next generation of the 8-bit up/down counter and adds:
- configurable width
- variable step size
- a run-time count limit
- a choice between wrap and saturate behaviour on overflow/underflow
- a registered boundary-event pulse

It is used as a general event/interval counter in datapath and timer blocks and runs in a single clock domain.

---
 rtl/updn_cntr_prog.sv | 137 +++++++++++++
 1 files changed

// File: rtl/updn_cntr_prog.sv
// ---------------------------------------------------------------------------
// updn_cntr_prog
// Programmable-limit up/down counter with wrap or saturate behaviour at the
// range boundaries (0 and limit) and a registered boundary-event pulse.
//
// Optional feature macro: CNTR_OVF_STICKY_EN
//   When defined, adds the ovf_sticky output and the ovf_clr input. The
//   sticky flag latches every boundary event until it is cleared.
//
// Parameters:
//   WIDTH   counter width in bits (2..32)
//   STEP_W  step input width in bits (1..WIDTH)
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   s_reset     synchronous clear of count and event outputs
//   ena         count enable
//   cnt_load    load cnt_in, clamped to limit
//   cnt_in      load value
//   up_dn       1 = count up, 0 = count down
//   step        amount added/subtracted per enabled cycle
//   limit       top of the legal count range 0..limit
//   sat_mode    1 = saturate at boundary, 0 = wrap
//   cnt_out     registered count
//   term_cnt    count is at the terminal value for the current direction
//   wrap_pulse  one-cycle registered boundary-event flag
//   ovf_sticky  sticky boundary-event flag      (CNTR_OVF_STICKY_EN only)
//   ovf_clr     clears ovf_sticky               (CNTR_OVF_STICKY_EN only)
// ---------------------------------------------------------------------------
module updn_cntr_prog #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_reset,
    input  logic              ena,
    input  logic              cnt_load,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              up_dn,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  limit,
    input  logic              sat_mode,
    output logic [WIDTH-1:0]  cnt_out,
    output logic              term_cnt,
    output logic              wrap_pulse
`ifdef CNTR_OVF_STICKY_EN
    ,
    output logic              ovf_sticky,
    input  logic              ovf_clr
`endif
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap_pulse;

    logic [WIDTH-1:0] w_step_ext;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_next;
    logic             w_event;

    assign w_step_ext = WIDTH'(step);
    // One extra bit so an up-count past the top of the WIDTH range is still
    // seen as exceeding limit instead of silently wrapping.
    assign w_sum      = {1'b0, r_cnt} + {1'b0, w_step_ext};
    assign w_load_val = (cnt_in > limit) ? limit : cnt_in;

    // Next count for an enabled cycle. A zero step never produces an event;
    // a nonzero step from a boundary in its own direction always does, which
    // covers the saturate-mode "already at boundary" case and limit = 0.
    always_comb begin
        w_next  = r_cnt;
        w_event = 1'b0;
        if (r_cnt > limit) begin
            // limit was lowered below the current count at run time
            w_next = limit;
        end else if (step == '0) begin
            w_next = r_cnt;
        end else if (up_dn) begin
            if (w_sum <= {1'b0, limit}) begin
                w_next = w_sum[WIDTH-1:0];
            end else begin
                w_event = 1'b1;
                w_next  = sat_mode ? limit : '0;
            end
        end else begin
            if (r_cnt >= w_step_ext) begin
                w_next = r_cnt - w_step_ext;
            end else begin
                w_event = 1'b1;
                w_next  = sat_mode ? '0 : limit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || s_reset) begin
            r_cnt        <= '0;
            r_wrap_pulse <= 1'b0;
        end else if (cnt_load) begin
            r_cnt        <= w_load_val;
            r_wrap_pulse <= 1'b0;
        end else if (ena) begin
            r_cnt        <= w_next;
            r_wrap_pulse <= w_event;
        end else begin
            r_wrap_pulse <= 1'b0;
        end
    end

`ifdef CNTR_OVF_STICKY_EN
    logic r_ovf_sticky;
    logic w_sticky_set;

    // Same condition that sets wrap_pulse; set has priority over ovf_clr.
    assign w_sticky_set = !cnt_load && ena && w_event;

    always_ff @(posedge clk) begin
        if (reset || s_reset) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_sticky_set) begin
            r_ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    assign ovf_sticky = r_ovf_sticky;
`endif

    assign cnt_out    = r_cnt;
    assign wrap_pulse = r_wrap_pulse;
    assign term_cnt   = up_dn ? (r_cnt == limit) : (r_cnt == '0);

endmodule
